// File: rtl/bram_capture_pkg.sv
// Shared types and default geometry for the BRAM capture block.
package bram_capture_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port RAM: synchronous write, registered read, no reset on the
// array or the read register so it maps onto a block RAM.
module capture_ram #(
    parameter int WIDTH  = 5,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port: one entry per enabled cycle.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read port: one-cycle latency, holds last value when not enabled.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/bram_capture.sv
// Captures a {over, data} sample stream into a BRAM while armed, tracks the
// first over-flagged entry, and serves the record through a registered read
// port once capture has finished.
module bram_capture
    import bram_capture_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_over,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_over,
    output logic              rd_valid,
    output logic              rd_oob,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              over_seen,
    output logic [ADDR_W-1:0] first_over
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                over_seen_q, over_seen_d;
    logic [ADDR_W-1:0]   first_over_q, first_over_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_oob_q, rd_oob_d;

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [DATA_W:0]     ram_rd;

    // Entries are written densely from 0, so the write pointer is simply the
    // low bits of the entry count; it never wraps because capture stops at DEPTH.
    assign wr_ptr = count_q[ADDR_W-1:0];

    // Next-state logic: start overrides everything, then per-state behaviour.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        over_seen_d  = over_seen_q;
        first_over_d = first_over_q;
        rd_valid_d   = 1'b0;
        rd_oob_d     = 1'b0;
        wr_en        = 1'b0;

        if (start) begin
            // Re-arm: the sample presented alongside start is dropped.
            state_d      = CAPTURE;
            count_d      = '0;
            over_seen_d  = 1'b0;
            first_over_d = '0;
        end else begin
            case (state_q)
                CAPTURE: begin
                    if (in_valid) begin
                        wr_en   = 1'b1;
                        count_d = count_q + ONE;
                        if (in_over && !over_seen_q) begin
                            over_seen_d  = 1'b1;
                            first_over_d = wr_ptr;
                        end
                        if (count_q == LAST_IDX) state_d = DONE;
                    end
                    // A sample arriving with stop is still kept.
                    if (stop) state_d = DONE;
                end
                DONE: begin
                    if (rd_req) begin
                        rd_valid_d = 1'b1;
                        rd_oob_d   = ({1'b0, rd_addr} >= count_q);
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == CAPTURE);
        done_d = (state_d == DONE);
    end

    // FSM, counters, flags and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            over_seen_q  <= 1'b0;
            first_over_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_oob_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            over_seen_q  <= over_seen_d;
            first_over_q <= first_over_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_valid_q   <= rd_valid_d;
            rd_oob_q     <= rd_oob_d;
        end
    end

    capture_ram #(
        .WIDTH  (DATA_W + 1),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data ({in_over, in_data}),
        .rd_en   (rd_valid_d),
        .rd_addr (rd_addr),
        .rd_data (ram_rd)
    );

    // The RAM read register is unreset and unmasked; gate it so read outputs
    // are zero outside a valid in-range response (including after reset).
    assign rd_data    = (rd_valid_q && !rd_oob_q) ? ram_rd[DATA_W-1:0] : '0;
    assign rd_over    = (rd_valid_q && !rd_oob_q) ? ram_rd[DATA_W]     : 1'b0;
    assign rd_valid   = rd_valid_q;
    assign rd_oob     = rd_oob_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign count      = count_q;
    assign over_seen  = over_seen_q;
    assign first_over = first_over_q;

endmodule

// File: tb/tb_bram_capture.sv
// Directed bench for bram_capture: capture, stop, restart, read gating, reset.
module tb_bram_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, in_valid = 1'b0, in_over = 1'b0, rd_req = 1'b0;
    logic [3:0] in_data = '0;
    logic [4:0] rd_addr = '0;
    logic [3:0] rd_data;
    logic       rd_over, rd_valid, rd_oob, busy, done, over_seen;
    logic [5:0] count;
    logic [4:0] first_over;

    int n_pass = 0;
    int n_total = 0;

    // status = {busy, done, count[5:0], over_seen, first_over[4:0]}
    logic [13:0] status;
    // rdout = {rd_valid, rd_oob, rd_over, rd_data[3:0]}
    logic [6:0]  rdout;
    assign status = {busy, done, count, over_seen, first_over};
    assign rdout  = {rd_valid, rd_oob, rd_over, rd_data};

    bram_capture dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .in_valid(in_valid), .in_data(in_data), .in_over(in_over),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_over(rd_over), .rd_valid(rd_valid), .rd_oob(rd_oob),
        .busy(busy), .done(done), .count(count),
        .over_seen(over_seen), .first_over(first_over)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_total++;
        if ({status, rdout} !== 21'd0) begin
            $display("FAIL reset_outputs: got %h expected 0", {status, rdout});
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        // rd_req and in_valid in IDLE must do nothing
        rd_req = 1'b1; in_valid = 1'b1;
        tick(); tick();
        rd_req = 1'b0; in_valid = 1'b0;
        n_total++;
        if ({status, rdout} !== 21'd0) begin
            $display("FAIL idle_ignore: got %h expected 0", {status, rdout});
        end else n_pass++;
    endtask

    task automatic test_full_capture();
        do_start();
        n_total++;
        if (status !== {1'b1, 1'b0, 6'd0, 1'b0, 5'd0}) begin
            $display("FAIL full_armed: got %h expected %h", status, {1'b1, 1'b0, 6'd0, 1'b0, 5'd0});
        end else n_pass++;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1; in_data = 4'(i % 16); in_over = (i >= 16);
            tick();
        end
        n_total++;
        if (status !== {1'b0, 1'b1, 6'd32, 1'b1, 5'd16}) begin
            $display("FAIL full_done: got %h expected %h", status, {1'b0, 1'b1, 6'd32, 1'b1, 5'd16});
        end else n_pass++;
        // extra samples and a stop after DONE: count saturates, state holds
        in_over = 1'b0; stop = 1'b1;
        tick(); tick();
        in_valid = 1'b0; stop = 1'b0;
        n_total++;
        if (status !== {1'b0, 1'b1, 6'd32, 1'b1, 5'd16}) begin
            $display("FAIL full_saturate: got %h expected %h", status, {1'b0, 1'b1, 6'd32, 1'b1, 5'd16});
        end else n_pass++;
        // back-to-back reads of the whole record
        for (int i = 0; i < 32; i++) begin
            rd_req = 1'b1; rd_addr = 5'(i);
            tick();
            n_total++;
            if (rdout !== {1'b1, 1'b0, (i >= 16), 4'(i % 16)}) begin
                $display("FAIL full_read[%0d]: got %h expected %h", i, rdout, {1'b1, 1'b0, (i >= 16), 4'(i % 16)});
            end else n_pass++;
        end
        rd_req = 1'b0;
        tick();
        n_total++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL full_read_end: got %b expected 0", rd_valid);
        end else n_pass++;
    endtask

    task automatic test_gapped();
        do_start();
        for (int i = 0; i < 62; i++) begin
            in_valid = (i % 2 == 0); in_data = 4'((i / 2) % 16); in_over = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        n_total++;
        if (status !== {1'b1, 1'b0, 6'd31, 1'b0, 5'd0}) begin
            $display("FAIL gap_count: got %h expected %h", status, {1'b1, 1'b0, 6'd31, 1'b0, 5'd0});
        end else n_pass++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_total++;
        if (status !== {1'b0, 1'b1, 6'd31, 1'b0, 5'd0}) begin
            $display("FAIL gap_stop: got %h expected %h", status, {1'b0, 1'b1, 6'd31, 1'b0, 5'd0});
        end else n_pass++;
        rd_req = 1'b1; rd_addr = 5'd31;
        tick();
        n_total++;
        if (rdout !== 7'b1100000) begin
            $display("FAIL gap_oob31: got %b expected 1100000", rdout);
        end else n_pass++;
        rd_addr = 5'd30;
        tick();
        rd_req = 1'b0;
        n_total++;
        if (rdout !== 7'b1001110) begin
            $display("FAIL gap_read30: got %b expected 1001110", rdout);
        end else n_pass++;
    endtask

    task automatic test_early_stop();
        do_start();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 4'(i + 1); in_over = 1'b0;
            tick();
        end
        in_data = 4'd9; in_over = 1'b1; stop = 1'b1;
        tick();
        in_valid = 1'b0; in_over = 1'b0; stop = 1'b0;
        n_total++;
        if (status !== {1'b0, 1'b1, 6'd6, 1'b1, 5'd5}) begin
            $display("FAIL early_stop: got %h expected %h", status, {1'b0, 1'b1, 6'd6, 1'b1, 5'd5});
        end else n_pass++;
        rd_req = 1'b1; rd_addr = 5'd5;
        tick();
        n_total++;
        if (rdout !== 7'b1011001) begin
            $display("FAIL early_addr5: got %b expected 1011001", rdout);
        end else n_pass++;
        rd_addr = 5'd6;
        tick();
        n_total++;
        if (rdout !== 7'b1100000) begin
            $display("FAIL early_oob6: got %b expected 1100000", rdout);
        end else n_pass++;
        rd_addr = 5'd0;
        tick();
        rd_req = 1'b0;
        n_total++;
        if (rdout !== 7'b1000001) begin
            $display("FAIL early_addr0: got %b expected 1000001", rdout);
        end else n_pass++;
    endtask

    task automatic test_start_stop();
        do_start();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 4'(i); in_over = (i == 1);
            tick();
        end
        n_total++;
        if (status !== {1'b1, 1'b0, 6'd3, 1'b1, 5'd1}) begin
            $display("FAIL ss_pre: got %h expected %h", status, {1'b1, 1'b0, 6'd3, 1'b1, 5'd1});
        end else n_pass++;
        start = 1'b1; stop = 1'b1; in_data = 4'hF; in_over = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0; in_over = 1'b0;
        n_total++;
        if (status !== {1'b1, 1'b0, 6'd0, 1'b0, 5'd0}) begin
            $display("FAIL ss_restart: got %h expected %h", status, {1'b1, 1'b0, 6'd0, 1'b0, 5'd0});
        end else n_pass++;
        in_data = 4'd7; tick();
        in_data = 4'd8; tick();
        in_valid = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        n_total++;
        if (status !== {1'b0, 1'b1, 6'd2, 1'b0, 5'd0}) begin
            $display("FAIL ss_after: got %h expected %h", status, {1'b0, 1'b1, 6'd2, 1'b0, 5'd0});
        end else n_pass++;
        rd_req = 1'b1; rd_addr = 5'd0;
        tick();
        rd_req = 1'b0;
        n_total++;
        if (rdout !== 7'b1000111) begin
            $display("FAIL ss_read0: got %b expected 1000111", rdout);
        end else n_pass++;
    endtask

    task automatic test_read_gating();
        do_start();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 4'(10 + i); in_over = 1'b0;
            rd_req = (i == 1); rd_addr = 5'd0;
            tick();
            if (i == 1) begin
                n_total++;
                if (rd_valid !== 1'b0) begin
                    $display("FAIL gate_capture: got %b expected 0", rd_valid);
                end else n_pass++;
            end
        end
        rd_req = 1'b0; in_valid = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1; rd_addr = 5'(2 + i);
            tick();
            n_total++;
            if (rdout !== {3'b100, 4'(12 + i)}) begin
                $display("FAIL gate_b2b[%0d]: got %b expected %b", i, rdout, {3'b100, 4'(12 + i)});
            end else n_pass++;
        end
        rd_req = 1'b0;
        tick();
        n_total++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL gate_b2b_end: got %b expected 0", rd_valid);
        end else n_pass++;
    endtask

    task automatic test_async_reset();
        do_start();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 4'(i); in_over = 1'b1;
            tick();
        end
        n_total++;
        if (status !== {1'b1, 1'b0, 6'd10, 1'b1, 5'd0}) begin
            $display("FAIL rst_pre: got %h expected %h", status, {1'b1, 1'b0, 6'd10, 1'b1, 5'd0});
        end else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({status, rdout} !== 21'd0) begin
            $display("FAIL rst_async: got %h expected 0", {status, rdout});
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        n_total++;
        if (status !== 14'd0) begin
            $display("FAIL rst_ignore: got %h expected 0", status);
        end else n_pass++;
        do_start();
        n_total++;
        if (status !== {1'b1, 1'b0, 6'd0, 1'b0, 5'd0}) begin
            $display("FAIL rst_rearm: got %h expected %h", status, {1'b1, 1'b0, 6'd0, 1'b0, 5'd0});
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_capture();
        test_gapped();
        test_early_stop();
        test_start_stop();
        test_read_gating();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
